// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard-controller FSM states and the bubble encoding
// that a flushed pipeline register loads.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hazard_state_t;

    // A bubble is an ADDI x0,x0,0 with every architectural side effect disabled.
    localparam logic [31:0] BUBBLE_INSTR      = 32'h0000_0013;
    localparam logic        BUBBLE_RD_EN      = 1'b0;
    localparam logic        BUBBLE_DMWRITE_EN = 1'b0;

    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Generic up-counter that sticks at all ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch / memory-wait hazard controller for a 5-stage pipeline.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] if_id_rs1_ad,
    input  logic [4:0] if_id_rs2_ad,
    input  logic       if_id_rs1_used,
    input  logic       if_id_rs2_used,
    input  logic [4:0] dec_ex_rd_ad,
    input  logic       dec_ex_rdEn,
    input  logic       dec_ex_DMread,
    input  logic       ex_branch_taken,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       dec_ex_en,
    output logic       ex_mem_en,
    output logic       mem_wb_en,
    output logic       if_id_flush,
    output logic       dec_ex_flush,
    output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [CNT_W-1:0] stall_cycles
   ,output logic [CNT_W-1:0] flush_count
`endif
);

    localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

    hazard_state_t         state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  load_use;
    logic                  mem_stall;

    assign load_use = dec_ex_DMread && dec_ex_rdEn && (dec_ex_rd_ad != 5'd0) &&
                      ((if_id_rs1_used && (dec_ex_rd_ad == if_id_rs1_ad)) ||
                       (if_id_rs2_used && (dec_ex_rd_ad == if_id_rs2_ad)));
    assign mem_stall = dmem_req && !dmem_ready;

    // Enables and flushes are a zero-latency function of state and inputs.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        dec_ex_en    = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        dec_ex_flush = 1'b0;
        if (rst_n && (state != ST_ERROR)) begin
            if (mem_stall) begin
                // Full freeze: a pending branch or load-use stays held in its register.
            end else if (ex_branch_taken) begin
                {pc_en, if_id_en, dec_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                if_id_flush  = 1'b1;
                dec_ex_flush = 1'b1;
            end else if (load_use) begin
                {dec_ex_en, ex_mem_en, mem_wb_en} = 3'b111;
                dec_ex_flush = 1'b1;
            end else begin
                {pc_en, if_id_en, dec_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_stall) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_stall) begin
                        state <= ST_RUN;
                    end else if (wait_cnt == MAX_WAIT_C) begin
                        state       <= ST_ERROR;
                        mem_timeout <= 1'b1;
                    end else if (wait_cnt != {WAIT_CNT_W{1'b1}}) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_ERROR: begin
                    // Terminal until reset.
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_en),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_id_flush),
        .count (flush_count)
    );
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: number of consecutive data-memory wait cycles before a timeout is declared (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports if_id_rs1_ad and if_id_rs2_ad, input, 5 each: source registers of the instruction in decode.
REQ-006 SHALL have ports if_id_rs1_used and if_id_rs2_used, input, 1 each: the decoded instruction actually reads that source.
REQ-007 SHALL have port dec_ex_rd_ad, input, 5; dec_ex_rdEn, input, 1; dec_ex_DMread, input, 1: the destination, write enable and load flag of the instruction in execute.
REQ-008 SHALL have port ex_branch_taken, input, 1: a branch or jump resolved taken in execute.
REQ-009 SHALL have ports dmem_req, input, 1 and dmem_ready, input, 1: the memory-stage access and its completion.
REQ-010 SHALL have ports pc_en, if_id_en, dec_ex_en, ex_mem_en, mem_wb_en, output, 1 each: pipeline register enables.
REQ-011 SHALL have ports if_id_flush and dec_ex_flush, output, 1 each: load a bubble (NOP, rdEn=0, DMwriteEn=0) into that register.
REQ-012 SHALL have port mem_timeout, output, 1: sticky error flag.
REQ-013 SHALL have ports stall_cycles and flush_count, output, CNT_W each, present only under the macro in REQ-030.

Function
REQ-014 SHALL define load_use = dec_ex_DMread & dec_ex_rdEn & (dec_ex_rd_ad != 0) & ((rs1_used & rd==rs1) | (rs2_used & rd==rs2)).
REQ-015 SHALL define mem_stall = dmem_req & ~dmem_ready.
REQ-016 SHALL implement the FSM states RUN, MEM_WAIT and ERROR; the reset state is RUN.
REQ-017 SHALL apply the following priority in RUN and MEM_WAIT, evaluated combinationally each cycle: mem_stall, then ex_branch_taken, then load_use, then normal.
REQ-018 SHALL, on mem_stall, drive all five enables to 0 and both flushes to 0 (full freeze); a taken branch or load-use in the same cycle is deferred because the frozen registers hold it.
REQ-019 SHALL, on a taken branch without mem_stall, drive all enables to 1 and if_id_flush = dec_ex_flush = 1 for that one cycle; any simultaneous load_use is ignored (the decode instruction is wrong-path).
REQ-020 SHALL, on load_use alone, drive pc_en = if_id_en = 0, dec_ex_flush = 1, and ex_mem_en = mem_wb_en = 1, giving exactly one bubble; the forwarding path then covers the dependency from MEM/WB.
REQ-021 SHALL, in the normal case, drive all enables to 1 and both flushes to 0.
REQ-022 SHALL transition RUN->MEM_WAIT on mem_stall, MEM_WAIT->RUN when mem_stall deasserts, and MEM_WAIT->ERROR when the wait counter equals MAX_WAIT with mem_stall still asserted.
REQ-023 SHALL use an 8-bit wait counter that clears on entering MEM_WAIT from RUN and increments on each cycle in MEM_WAIT with mem_stall asserted, without wrapping.
REQ-024 SHALL, in ERROR, hold all enables at 0, both flushes at 0 and mem_timeout at 1 until reset, ignoring all inputs.
REQ-025 SHALL have a combinational latency of zero cycles from inputs to enable and flush outputs; only the state and counters are registered.

Reset
REQ-026 SHALL, on rst_n low at any time including mid-MEM_WAIT: set state = RUN, wait counter = 0, mem_timeout = 0 and both perf counters = 0.
REQ-027 SHALL, while rst_n is low, drive all enables to 0 and both flushes to 0.
REQ-028 SHALL, on the first edge after rst_n is released, apply the normal REQ-017 priority.

Configuration
REQ-029 SHALL behave as follows without the macro: stall_cycles and flush_count ports and their logic are absent.
REQ-030 SHALL behave as follows with HAZARD_PERF_CNT_EN defined: stall_cycles increments on each cycle with pc_en = 0 outside reset, and flush_count increments on each cycle with if_id_flush = 1; both saturate at all ones.

Structure
REQ-031 SHALL place the FSM state enum and the bubble-encoding constants in the shared package pipeline_pkg.
REQ-032 SHALL implement the hazard-detection logic as a single module with no sub-module; the perf counters may be one generic sub-module, sat_counter, instantiated twice.

Verification
REQ-033 SHALL verify: load x5 in EX, decode rs1=5 with used=1 -> one cycle of pc_en=0, if_id_en=0, dec_ex_flush=1; with rs1_used=0 -> no stall.
REQ-034 SHALL verify: load with rd=0 matching rs1=0 -> no stall.
REQ-035 SHALL verify: ex_branch_taken=1 together with load_use=1 -> both flushes=1, pc_en=1, and flush_count +1.
REQ-036 SHALL verify: dmem_ready low for 3 cycles with a branch in EX -> 3 frozen cycles, then the flush in the cycle after ready rises.
REQ-037 SHALL verify: MAX_WAIT=4 with dmem_ready held low -> ERROR and mem_timeout=1 after the counter reaches 4, held until rst_n pulses low.
REQ-038 SHALL verify: rst_n asserted mid-MEM_WAIT -> all outputs 0 immediately, and state RUN after release.
